// File: rtl/if_id_stage_pkg.sv
// Shared OTTER pipeline definitions: datapath width, bubble instruction and
// base opcodes used by the decode-side hazard and forwarding logic.
package otter_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [6:0] {
    OP     = 7'b0110011,
    OP_IMM = 7'b0010011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    BRANCH = 7'b1100011,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    SYSTEM = 7'b1110011
  } opcode_e;

endpackage

// File: rtl/if_id_stage_ld_hazard_unit.sv
// Load-use hazard detect: decodes which source fields an instruction really
// reads and compares them against the destination of a load sitting in EX.
module ld_hazard_unit
  import otter_pkg::*;
(
  input  logic       valid,
  input  logic [6:0] opcode,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       ld_haz
);

  logic uses_rs1;
  logic uses_rs2;

  // Unknown opcodes are treated as rs1 readers so a hazard is never missed.
  always_comb begin
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (opcode)
      LUI, AUIPC, JAL:     uses_rs1 = 1'b0;
      OP, STORE, BRANCH:   uses_rs2 = 1'b1;
      default: ;
    endcase
  end

  assign ld_haz = valid && ex_mem_read && (ex_rd != 5'd0) &&
                  (((ex_rd == rs1) && uses_rs1) || ((ex_rd == rs2) && uses_rs2));

endmodule

// File: rtl/if_id_stage.sv
// IF/ID boundary register with stall hold buffer, two-bubble flush shadow and
// load-use detection. Define IFID_PERF_CNT_EN to add stall/flush counters.
module if_id_stage #(
  parameter int          XLEN      = otter_pkg::XLEN,
  parameter logic [31:0] NOP_INSTR = otter_pkg::NOP_INSTR
) (
  input  logic            CLK,
  input  logic            EXT_RESET_N,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [31:0]     mem_instr,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  output logic [XLEN-1:0] de_pc,
  output logic [31:0]     de_instr,
  output logic            de_valid,
  output logic [4:0]      de_rs1,
  output logic [4:0]      de_rs2,
  output logic            ld_haz
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  logic [XLEN-1:0] pc_q;
  logic            valid_q;
  logic [31:0]     hold_q;
  logic            hold_v;
  logic            flush_shadow;

  // Memory read is disabled during a stall, so the word seen on the first
  // stall cycle is the only copy and must be replayed from the hold register.
  assign de_pc    = pc_q;
  assign de_valid = valid_q;
  assign de_instr = !valid_q ? NOP_INSTR : (hold_v ? hold_q : mem_instr);
  assign de_rs1   = valid_q ? de_instr[19:15] : 5'd0;
  assign de_rs2   = valid_q ? de_instr[24:20] : 5'd0;

  ld_hazard_unit u_ld_hazard (
    .valid       (valid_q),
    .opcode      (de_instr[6:0]),
    .rs1         (de_rs1),
    .rs2         (de_rs2),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .ld_haz      (ld_haz)
  );

  always_ff @(posedge CLK) begin
    if (!EXT_RESET_N) begin
      pc_q         <= '0;
      valid_q      <= 1'b0;
      hold_q       <= '0;
      hold_v       <= 1'b0;
      flush_shadow <= 1'b0;
    end else if (flush) begin
      pc_q         <= fetch_pc;
      valid_q      <= 1'b0;
      hold_v       <= 1'b0;
      flush_shadow <= 1'b1;
    end else if (ld_haz) begin
      if (!hold_v) begin
        hold_q <= mem_instr;
        hold_v <= 1'b1;
      end
    end else begin
      // The word arriving during the shadow cycle is wrong-path and dropped.
      pc_q         <= fetch_pc;
      valid_q      <= !flush_shadow;
      hold_v       <= 1'b0;
      flush_shadow <= 1'b0;
    end
  end

`ifdef IFID_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (!EXT_RESET_N) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (ld_haz && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      if (flush && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: directed cycles push expected decode-side
// outputs, a negedge monitor pops and compares them.
module tb_if_id_stage;
  import otter_pkg::*;

  localparam logic [31:0] I_A    = 32'h0010_0093; // addi x1,x0,1
  localparam logic [31:0] I_B    = 32'h0001_2283; // lw   x5,0(x2)
  localparam logic [31:0] I_C    = 32'h0012_8333; // add  x6,x5,x1
  localparam logic [31:0] I_D    = 32'h0002_82B7; // lui  x5,0x28 (rs1 field = 5)
  localparam logic [31:0] I_E    = 32'h0071_A023; // sw   x7,0(x3)
  localparam logic [31:0] I_F    = 32'h0000_03B3; // add  x7,x0,x0
  localparam logic [31:0] I_G    = 32'h0051_A023; // sw   x5,0(x3)
  localparam logic [31:0] I_H    = 32'h0050_0513; // addi x10,x0,5
  localparam logic [31:0] I_I    = 32'h0060_0593; // addi x11,x0,6
  localparam logic [31:0] GARB   = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        EXT_RESET_N;
  logic [31:0] fetch_pc;
  logic [31:0] mem_instr;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        flush;
  logic [31:0] de_pc;
  logic [31:0] de_instr;
  logic        de_valid;
  logic [4:0]  de_rs1;
  logic [4:0]  de_rs2;
  logic        ld_haz;
`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  always #5 CLK = ~CLK;

  if_id_stage dut (
    .CLK         (CLK),
    .EXT_RESET_N (EXT_RESET_N),
    .fetch_pc    (fetch_pc),
    .mem_instr   (mem_instr),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .flush       (flush),
    .de_pc       (de_pc),
    .de_instr    (de_instr),
    .de_valid    (de_valid),
    .de_rs1      (de_rs1),
    .de_rs2      (de_rs2),
    .ld_haz      (ld_haz)
`ifdef IFID_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  typedef struct {
    string       tag;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        haz;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   compared   = 0;
  int   mismatched = 0;
  int   m_stall    = 0;
  int   m_flush    = 0;

  task automatic chk(input string tag, input string field,
                     input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s.%s: got %h want %h", tag, field, got, want);
    end
  endtask

  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk(mon_e.tag, "de_valid", {31'd0, de_valid}, {31'd0, mon_e.valid});
      chk(mon_e.tag, "de_pc",    de_pc,             mon_e.pc);
      chk(mon_e.tag, "de_instr", de_instr,          mon_e.instr);
      chk(mon_e.tag, "ld_haz",   {31'd0, ld_haz},   {31'd0, mon_e.haz});
      chk(mon_e.tag, "de_rs1",   {27'd0, de_rs1},   {27'd0, mon_e.rs1});
      chk(mon_e.tag, "de_rs2",   {27'd0, de_rs2},   {27'd0, mon_e.rs2});
`ifdef IFID_PERF_CNT_EN
      chk(mon_e.tag, "stall_cnt", stall_cnt, mon_e.scnt);
      chk(mon_e.tag, "flush_cnt", flush_cnt, mon_e.fcnt);
`endif
    end
  end

  // One clock cycle: drive inputs just after the edge, push what decode must
  // show during this cycle, then advance the counter model past the next edge.
  task automatic step(input string tag, input bit rst_n, input logic [31:0] fpc,
                      input logic [31:0] mi, input bit emr, input logic [4:0] erd,
                      input bit fl, input bit ev, input logic [31:0] epc,
                      input logic [31:0] einstr, input bit ehaz);
    exp_t e;
    @(posedge CLK);
    #1;
    EXT_RESET_N = rst_n;
    fetch_pc    = fpc;
    mem_instr   = mi;
    ex_mem_read = emr;
    ex_rd       = erd;
    flush       = fl;
    e.tag   = tag;
    e.valid = ev;
    e.pc    = epc;
    e.instr = einstr;
    e.haz   = ehaz;
    e.rs1   = ev ? einstr[19:15] : 5'd0;
    e.rs2   = ev ? einstr[24:20] : 5'd0;
    e.scnt  = m_stall;
    e.fcnt  = m_flush;
    sb.push_back(e);
    if (!rst_n) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (ehaz) m_stall++;
      if (fl)   m_flush++;
    end
  endtask

  initial begin
    EXT_RESET_N = 1'b0;
    fetch_pc    = '0;
    mem_instr   = GARB;
    ex_mem_read = 1'b0;
    ex_rd       = '0;
    flush       = 1'b0;
    repeat (2) @(posedge CLK);

    //   tag          rst fetch_pc  mem_instr emr erd fl  valid pc        instr  haz
    step("reset",     1, 32'h000, GARB, 0, 5'd0, 0, 0, 32'h000, NOP,  0);
    step("seq_a",     1, 32'h004, I_A,  0, 5'd0, 0, 1, 32'h000, I_A,  0);
    step("seq_b",     1, 32'h008, I_B,  0, 5'd0, 0, 1, 32'h004, I_B,  0);
    step("ld_use",    1, 32'h00C, I_C,  1, 5'd5, 0, 1, 32'h008, I_C,  1);
    step("ld_held",   1, 32'h00C, GARB, 0, 5'd0, 0, 1, 32'h008, I_C,  0);
    step("lui_nohaz", 1, 32'h010, I_D,  1, 5'd5, 0, 1, 32'h00C, I_D,  0);
    step("st_nohaz",  1, 32'h014, I_E,  1, 5'd5, 0, 1, 32'h010, I_E,  0);
    step("x0_nohaz",  1, 32'h018, I_F,  1, 5'd0, 0, 1, 32'h014, I_F,  0);
    step("st_rs2haz", 1, 32'h01C, I_G,  1, 5'd5, 0, 1, 32'h018, I_G,  1);
    step("flush_haz", 1, 32'h01C, GARB, 1, 5'd5, 1, 1, 32'h018, I_G,  1);
    step("bubble1",   1, 32'h200, GARB, 1, 5'd5, 0, 0, 32'h01C, NOP,  0);
    step("bubble2",   1, 32'h100, GARB, 0, 5'd0, 0, 0, 32'h200, NOP,  0);
    step("target",    1, 32'h104, I_H,  0, 5'd0, 0, 1, 32'h100, I_H,  0);
    step("flush_a",   1, 32'h108, I_I,  0, 5'd0, 1, 1, 32'h104, I_I,  0);
    step("reflush",   1, 32'h300, GARB, 0, 5'd0, 1, 0, 32'h108, NOP,  0);
    step("ext_bub2",  1, 32'h304, GARB, 0, 5'd0, 0, 0, 32'h300, NOP,  0);
    step("ext_bub3",  1, 32'h308, GARB, 0, 5'd0, 0, 0, 32'h304, NOP,  0);
    step("stall2",    1, 32'h30C, I_C,  1, 5'd5, 0, 1, 32'h308, I_C,  1);
    step("rst_stall", 0, 32'h30C, GARB, 1, 5'd5, 0, 1, 32'h308, I_C,  1);
    step("post_rst",  1, 32'h000, GARB, 1, 5'd5, 0, 0, 32'h000, NOP,  0);
    step("restart",   1, 32'h004, I_A,  0, 5'd0, 0, 1, 32'h000, I_A,  0);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge CLK);
    #1;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
